// File: rtl/fb_pkg.sv
// Shared constants, state encoding and register bit positions for the
// framebuffer write path.
package fb_pkg;

    localparam int          FB_ADDR_BITS = 9;
    localparam int          FB_DATA_BITS = 8;
    localparam logic [31:0] FB_BASE      = 32'h0000_1000;
    localparam logic [31:0] CTRL_ADDR    = 32'h0000_1200;
    localparam logic [7:0]  CLEAR_VALUE  = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } fb_state_t;

    // Status byte layout: [4:0] fifo count, then flag bits.
    localparam int ST_CNT_LSB  = 0;
    localparam int ST_CNT_BITS = 5;
    localparam int ST_OVF_BIT  = 5;
    localparam int ST_CLRP_BIT = 6;
    localparam int ST_BUSY_BIT = 7;

    // Control register bits.
    localparam int CLR_BIT     = 0;
    localparam int OVF_CLR_BIT = 1;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous store queue with occupancy count and a single-cycle flush.
// Pushes while full and pops while empty are ignored.
module fb_wr_fifo #(
    parameter int WIDTH    = 17,
    parameter int DEPTH    = 16,
    parameter int CNT_BITS = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                push,
    input  logic                pop,
    input  logic [WIDTH-1:0]    wdata,
    output logic [WIDTH-1:0]    rdata,
    output logic                full,
    output logic                empty,
    output logic [CNT_BITS-1:0] count
);

    localparam int PTR_BITS = $clog2(DEPTH);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic                push_ok;
    logic                pop_ok;

    assign full    = (count == CNT_BITS'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array: written on accepted pushes only, never reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and count; flush empties the queue like reset does.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_BITS'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_BITS'(1);
            end
            count <= count + CNT_BITS'(push_ok) - CNT_BITS'(pop_ok);
        end
    end

endmodule

// File: rtl/fb_writer.sv
// Queues CPU byte stores aimed at the framebuffer window and commits them
// to the framebuffer write port only during vblank. Also performs a
// hardware full-screen clear and reports a status byte.
module fb_writer
    import fb_pkg::*;
#(
    parameter int          ADDR_BITS   = FB_ADDR_BITS,
    parameter int          DATA_BITS   = FB_DATA_BITS,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [31:0] FB_BASE     = fb_pkg::FB_BASE,
    parameter logic [31:0] CTRL_ADDR   = fb_pkg::CTRL_ADDR,
    parameter logic [7:0]  CLEAR_VALUE = fb_pkg::CLEAR_VALUE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_we,
    input  logic [31:0]          cpu_addr,
    input  logic [DATA_BITS-1:0] cpu_wdata,
    input  logic                 vblank,
    output logic                 fb_we,
    output logic [ADDR_BITS-1:0] fb_addr,
    output logic [DATA_BITS-1:0] fb_wdata,
    output logic [7:0]           status
);

    localparam int ENTRY_BITS = ADDR_BITS + DATA_BITS;
    localparam int CNT_BITS   = $clog2(FIFO_DEPTH) + 1;
    // Window end computed in 33 bits so a window at the top of the map
    // cannot wrap.
    localparam logic [32:0] WIN_LO = {1'b0, FB_BASE};
    localparam logic [32:0] WIN_HI = {1'b0, FB_BASE} + (33'd1 << ADDR_BITS);
    localparam logic [ADDR_BITS-1:0] LAST_CELL = '1;

    fb_state_t             state, state_n;
    logic [ADDR_BITS-1:0]  clear_ptr, clear_ptr_n;
    logic                  clear_pending, clear_pending_n;
    logic                  overflow;
    logic                  fb_we_n;
    logic [ADDR_BITS-1:0]  fb_addr_n;
    logic [DATA_BITS-1:0]  fb_wdata_n;

    logic                  in_window;
    logic                  ctrl_wr;
    logic                  clr_req;
    logic                  ovf_clr_req;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [CNT_BITS-1:0]   count;
    logic [ENTRY_BITS-1:0] head;

    assign in_window   = ({1'b0, cpu_addr} >= WIN_LO) && ({1'b0, cpu_addr} < WIN_HI);
    assign ctrl_wr     = cpu_we && (cpu_addr == CTRL_ADDR);
    assign clr_req     = ctrl_wr && cpu_wdata[CLR_BIT];
    assign ovf_clr_req = ctrl_wr && cpu_wdata[OVF_CLR_BIT];
    assign push        = cpu_we && in_window;

    fb_wr_fifo #(
        .WIDTH    (ENTRY_BITS),
        .DEPTH    (FIFO_DEPTH),
        .CNT_BITS (CNT_BITS)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (clr_req),
        .push  (push),
        .pop   (pop),
        .wdata ({cpu_addr[ADDR_BITS-1:0], cpu_wdata}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Next-state, pop and registered-write selection.
    always_comb begin
        state_n         = state;
        pop             = 1'b0;
        fb_we_n         = 1'b0;
        fb_addr_n       = fb_addr;
        fb_wdata_n      = fb_wdata;
        clear_ptr_n     = clear_ptr;
        clear_pending_n = clear_pending;
        case (state)
            IDLE: begin
                if (!clr_req && vblank && clear_pending) begin
                    state_n = CLEAR;
                end else if (!clr_req && vblank && !empty) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (clr_req || empty) begin
                    state_n = IDLE;
                end else if (vblank) begin
                    pop        = 1'b1;
                    fb_we_n    = 1'b1;
                    fb_addr_n  = head[ENTRY_BITS-1:DATA_BITS];
                    fb_wdata_n = head[DATA_BITS-1:0];
                end
            end
            CLEAR: begin
                if (vblank && !clr_req) begin
                    fb_we_n     = 1'b1;
                    fb_addr_n   = clear_ptr;
                    fb_wdata_n  = DATA_BITS'(CLEAR_VALUE);
                    clear_ptr_n = clear_ptr + ADDR_BITS'(1);
                    if (clear_ptr == LAST_CELL) begin
                        clear_pending_n = 1'b0;
                        state_n         = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // A clear request restarts the sweep from cell 0 in any state.
        if (clr_req) begin
            clear_pending_n = 1'b1;
            clear_ptr_n     = '0;
        end
    end

    // State, clear sweep and framebuffer port registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            clear_ptr     <= '0;
            clear_pending <= 1'b0;
            fb_we         <= 1'b0;
            fb_addr       <= '0;
            fb_wdata      <= '0;
        end else begin
            state         <= state_n;
            clear_ptr     <= clear_ptr_n;
            clear_pending <= clear_pending_n;
            fb_we         <= fb_we_n;
            fb_addr       <= fb_addr_n;
            fb_wdata      <= fb_wdata_n;
        end
    end

    // Sticky overflow: set by a store dropped on a full queue, cleared by CTRL.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (ovf_clr_req) begin
            overflow <= 1'b0;
        end else if (push && full) begin
            overflow <= 1'b1;
        end
    end

    // CPU-visible status byte.
    always_comb begin
        status                                   = '0;
        status[ST_CNT_LSB +: ST_CNT_BITS]        = ST_CNT_BITS'(count);
        status[ST_OVF_BIT]                       = overflow;
        status[ST_CLRP_BIT]                      = clear_pending;
        status[ST_BUSY_BIT]                      = (state != IDLE) || clear_pending || !empty;
    end

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer: store queueing, vblank-gated drain,
// overflow, hardware clear with pause/resume, window decode and reset abort.
module tb_fb_writer;

    logic        clk;
    logic        reset;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        vblank;
    logic        fb_we;
    logic [8:0]  fb_addr;
    logic [7:0]  fb_wdata;
    logic [7:0]  status;

    int n_checks = 0;
    int n_fail   = 0;

    logic [16:0] exp_q[$];
    logic [16:0] obs_q[$];

    fb_writer dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .vblank    (vblank),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_wdata  (fb_wdata),
        .status    (status)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Write monitor: capture every framebuffer write mid-cycle.
    always @(negedge clk) begin
        if (!reset && fb_we) begin
            obs_q.push_back({fb_addr, fb_wdata});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_store(input logic [31:0] addr, input logic [7:0] data);
        cpu_we    = 1'b1;
        cpu_addr  = addr;
        cpu_wdata = data;
        tick();
        cpu_we    = 1'b0;
    endtask

    // Compare captured writes against the expected queue, in order.
    task automatic check_writes(input string tag);
        check_eq({tag, "_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            check_eq(tag, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        reset     = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        vblank    = 1'b0;

        // 1: reset
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_eq("rst_fb_we", fb_we, 0);
        check_eq("rst_fb_addr", fb_addr, 0);
        check_eq("rst_fb_wdata", fb_wdata, 0);
        check_eq("rst_status", status, 8'h00);

        // 2: queued stores held until vblank, then drained in order
        cpu_store(32'h1005, 8'hAA);
        cpu_store(32'h1006, 8'h55);
        cpu_store(32'h11FF, 8'h01);
        tick();
        tick();
        check_eq("t2_no_write", obs_q.size(), 0);
        check_eq("t2_status_q", status, 8'h83);
        vblank = 1'b1;
        tick();
        check_eq("t2_v1_we", fb_we, 0);
        tick();
        check_eq("t2_v2", {fb_we, fb_addr, fb_wdata}, {1'b1, 9'h005, 8'hAA});
        tick();
        check_eq("t2_v3", {fb_we, fb_addr, fb_wdata}, {1'b1, 9'h006, 8'h55});
        tick();
        check_eq("t2_v4", {fb_we, fb_addr, fb_wdata}, {1'b1, 9'h1FF, 8'h01});
        tick();
        check_eq("t2_v5_we", fb_we, 0);
        tick();
        check_eq("t2_status_done", status, 8'h00);
        vblank = 1'b0;
        obs_q.delete();

        // 3: overflow on the 17th store, sticky until CTRL<-02
        for (int i = 0; i < 17; i++) begin
            cpu_store(32'h1000 + 32'(i), 8'h30 + 8'(i));
            if (i < 16) exp_q.push_back({9'(i), 8'h30 + 8'(i)});
        end
        check_eq("t3_status_full", status, 8'hB0);
        vblank = 1'b1;
        for (int i = 0; i < 64 && status[7]; i++) tick();
        check_eq("t3_status_drained", status, 8'h20);
        vblank = 1'b0;
        tick();
        check_writes("t3_write");
        cpu_store(32'h1200, 8'h02);
        check_eq("t3_ovf_clr", status, 8'h00);

        // 4: clear request flushes the queue and sweeps all 512 cells
        cpu_store(32'h1010, 8'h11);
        cpu_store(32'h1020, 8'h22);
        check_eq("t4_status_q", status, 8'h82);
        cpu_store(32'h1200, 8'h01);
        check_eq("t4_status_clr", status, 8'hC0);
        vblank = 1'b1;
        tick();
        for (int i = 0; i < 512; i++) begin
            tick();
            check_eq("t4_clear", {fb_we, fb_addr, fb_wdata}, {1'b1, 9'(i), 8'h00});
        end
        check_eq("t4_status_done", status, 8'h00);
        tick();
        check_eq("t4_we_after", fb_we, 0);
        vblank = 1'b0;
        obs_q.delete();

        // 5: clear paused by vblank, store during pause written after sweep
        cpu_store(32'h1200, 8'h01);
        vblank = 1'b1;
        tick();
        for (int i = 0; i <= 100; i++) begin
            tick();
            check_eq("t5_clear_a", {fb_we, fb_addr, fb_wdata}, {1'b1, 9'(i), 8'h00});
        end
        vblank = 1'b0;
        tick();
        check_eq("t5_pause_we0", fb_we, 0);
        cpu_store(32'h1077, 8'h5A);
        check_eq("t5_pause_we1", fb_we, 0);
        check_eq("t5_pause_status", status, 8'hC1);
        tick();
        check_eq("t5_pause_we2", fb_we, 0);
        vblank = 1'b1;
        for (int i = 101; i < 512; i++) begin
            tick();
            check_eq("t5_clear_b", {fb_we, fb_addr, fb_wdata}, {1'b1, 9'(i), 8'h00});
        end
        tick();
        check_eq("t5_gap_we", fb_we, 0);
        tick();
        check_eq("t5_store", {fb_we, fb_addr, fb_wdata}, {1'b1, 9'h077, 8'h5A});
        tick();
        tick();
        check_eq("t5_status_done", status, 8'h00);
        vblank = 1'b0;
        obs_q.delete();

        // 6: window boundaries and reset during a drain
        cpu_store(32'h0FFF, 8'h77);
        cpu_store(32'h1201, 8'h77);
        check_eq("t6_outside", status, 8'h00);
        for (int i = 0; i < 5; i++) begin
            cpu_store(32'h1100 + 32'(i), 8'hC0 + 8'(i));
        end
        check_eq("t6_status_q", status, 8'h85);
        vblank = 1'b1;
        tick();
        tick();
        check_eq("t6_w0", {fb_we, fb_addr, fb_wdata}, {1'b1, 9'h100, 8'hC0});
        tick();
        check_eq("t6_w1", {fb_we, fb_addr, fb_wdata}, {1'b1, 9'h101, 8'hC1});
        reset = 1'b1;
        tick();
        check_eq("t6_rst_we", fb_we, 0);
        tick();
        reset = 1'b0;
        tick();
        check_eq("t6_rst_status", status, 8'h00);
        check_eq("t6_rst_we_after", fb_we, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
